cv32e40p_obi_mem_responder: RTL



---
 rtl/cv32e40p_obi_resp_pkg.sv | 24 ++
 rtl/cv32e40p_obi_lfsr16.sv | 23 ++
 rtl/cv32e40p_obi_mem_responder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cv32e40p_obi_resp_pkg.sv
// Shared types and helpers for the OBI memory responder: response pipeline stage
// layout, bus widths and the byte-enable merge used on writes.
package cv32e40p_obi_resp_pkg;

  localparam int OBI_DW  = 32;
  localparam int OBI_BEW = 4;

  typedef struct packed {
    logic              valid;
    logic [OBI_DW-1:0] rdata;
  } obi_resp_stage_t;

  function automatic logic [OBI_DW-1:0] be_merge(input logic [OBI_DW-1:0]  old,
                                                 input logic [OBI_DW-1:0]  wdata,
                                                 input logic [OBI_BEW-1:0] be);
    logic [OBI_DW-1:0] merged;
    merged = old;
    for (int k = 0; k < OBI_BEW; k++) begin
      if (be[k]) merged[8*k +: 8] = wdata[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/cv32e40p_obi_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle; feeds the
// random grant stall of the OBI responder when CV32E40P_OBI_RAND_STALL_EN is set.
module cv32e40p_obi_lfsr16 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] seed,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= seed;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI 1.0 memory-side responder: word RAM with byte-enable writes, fixed-latency
// in-order responses and bounded outstanding transactions.
// Optional random grant stall: define CV32E40P_OBI_RAND_STALL_EN.
module cv32e40p_obi_mem_responder
  import cv32e40p_obi_resp_pkg::*;
#(
  parameter int          MEM_WORDS       = 1024,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                stall_i,
  input  logic                req_i,
  output logic                gnt_o,
  input  logic [31:0]         addr_i,
  input  logic                we_i,
  input  logic [OBI_BEW-1:0]  be_i,
  input  logic [OBI_DW-1:0]   wdata_i,
  output logic                rvalid_o,
  output logic [OBI_DW-1:0]   rdata_o
);

  localparam int             AW      = $clog2(MEM_WORDS);
  localparam int             CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0]  MAX_OUT = CW'(MAX_OUTSTANDING);

  if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_mem_words
    $error("MEM_WORDS must be a power of two >= 2");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("LATENCY must be in 1..8");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY + 1) begin : g_bad_max_out
    $error("MAX_OUTSTANDING must be in 1..LATENCY+1");
  end
  if (LFSR_SEED == 16'h0) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

  logic [AW-1:0]     idx;
  logic              accept;
  logic              rand_stall;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_eff;
  logic [OBI_DW-1:0] mem_rd, mem_wr_d;
  logic [OBI_DW-1:0] mem_q [MEM_WORDS];
  obi_resp_stage_t   pipe_q [LATENCY];
  obi_resp_stage_t   pipe_d [LATENCY];
  logic              unused_addr;

  assign idx         = addr_i[AW+1:2];
  assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

`ifdef CV32E40P_OBI_RAND_STALL_EN
  logic [15:0] lfsr;
  logic        unused_lfsr;

  cv32e40p_obi_lfsr16 u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .seed   (LFSR_SEED),
    .lfsr_o (lfsr)
  );

  assign rand_stall  = (lfsr[1:0] == 2'b00);
  assign unused_lfsr = ^lfsr[15:2];
`else
  assign rand_stall = 1'b0;
`endif

  // A response leaving the pipeline this cycle frees its slot immediately, so
  // grant re-opens in the same cycle rvalid_o is high.
  always_comb begin
    cnt_eff = cnt_q - CW'(rvalid_o);
    gnt_o   = rst_ni & req_i & ~stall_i & (cnt_eff < MAX_OUT) & ~rand_stall;
    accept  = req_i & gnt_o;
    cnt_d   = cnt_eff + CW'(accept);
  end

  always_comb begin
    mem_rd   = mem_q[idx];
    mem_wr_d = be_merge(mem_rd, wdata_i, be_i);
  end

  // NOTE: the RAM array is deliberately left without reset so it maps onto a
  // plain memory macro; contents survive rst_ni by design.
  always_ff @(posedge clk_i) begin
    if (accept && we_i) mem_q[idx] <= mem_wr_d;
  end

  // Valid shifts every cycle; data only moves with a valid token, so the last
  // stage holds the previous response while rvalid_o is low.
  always_comb begin
    // NOTE: default every stage first so no branch leaves pipe_d unassigned,
    // which would otherwise infer latches.
    for (int i = 0; i < LATENCY; i++) pipe_d[i] = pipe_q[i];
    pipe_d[0].valid = accept;
    if (accept) pipe_d[0].rdata = we_i ? '0 : mem_rd;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i].valid = pipe_q[i-1].valid;
      if (pipe_q[i-1].valid) pipe_d[i].rdata = pipe_q[i-1].rdata;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign rvalid_o = pipe_q[LATENCY-1].valid;
  assign rdata_o  = pipe_q[LATENCY-1].rdata;

  a_cnt_bounds: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cnt_q <= MAX_OUT) && !(rvalid_o && (cnt_q == '0)))
    else $error("outstanding counter out of range");

endmodule
